// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multi-cycle RV32I main control FSM with memory handshake and retire counter
module main_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUOp,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_ILLEGAL
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire_d;

    // Next-state selection; only FETCH, MEMREAD and MEMWRITE look at mem_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXEC_R:   state_d = S_ALUWB;
            S_EXEC_I:   state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_ILLEGAL;
        endcase
    end

    // An instruction retires on the edge that returns the FSM to FETCH
    always_comb begin
        retire_d = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                   (state_q == S_BRANCH) || ((state_q == S_MEMWRITE) && mem_ready);
    end

    // State register and retire counter, both cleared asynchronously
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire_d) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Datapath controls decoded from the current state; strobes are masked while in reset
    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 2'b00;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUOp     = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                ALUOp   = 2'b00;
            end
            S_EXEC_I: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b11;
            end
            S_ALUWB: begin
                ResultSrc = 2'b00;
                RegWrite  = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b00;
                ALUOp     = 2'b01;
                ResultSrc = 2'b00;
                case (funct3)
                    3'b000:  PCWrite = zero;
                    3'b001:  PCWrite = ~zero;
                    default: PCWrite = 1'b0;
                endcase
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ALUOp     = 2'b10;
                ResultSrc = 2'b00;
                PCWrite   = 1'b1;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (!RST_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            MemRead  = 1'b0;
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - self-checking bench for main_control_fsm
module tb_main_control_fsm;

    logic        CLK;
    logic        RST_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
    logic        illegal;
    logic [31:0] retired;

    main_control_fsm #(.CNT_W(32)) dut (
        .CLK(CLK), .RST_n(RST_n), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .illegal(illegal),
        .retired(retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [14:0] exp_vec;
    logic [31:0] exp_ret;
    bit          exp_valid = 1'b0;
    logic [31:0] model_ret = 32'd0;
    int          n_cyc;
    int          ir_cnt, mw_cnt, rw_cnt, pc_cnt;

    // {PCWrite,IRWrite,AdrSrc,MemRead,MemWrite,RegWrite,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,illegal}
    function automatic logic [14:0] vec(input logic pcw, input logic irw, input logic adr,
                                        input logic mr, input logic mw, input logic rw,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [1:0] rs, input logic [1:0] op,
                                        input logic ill);
        return {pcw, irw, adr, mr, mw, rw, sa, sb, rs, op, ill};
    endfunction

    wire [14:0] act_vec = {PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
                           ALUSrcA, ALUSrcB, ResultSrc, ALUOp, illegal};

    // Single compare process: outputs against the model expectation, mid-cycle
    always @(negedge CLK) begin
        if (exp_valid) begin
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL outputs t=%0t got=%b want=%b", $time, act_vec, exp_vec);
            end
            n_cmp++;
            if (retired !== exp_ret) begin
                n_bad++;
                $display("FAIL retired t=%0t got=%0d want=%0d", $time, retired, exp_ret);
            end
            if (IRWrite)  ir_cnt++;
            if (MemWrite) mw_cnt++;
            if (RegWrite) rw_cnt++;
            if (PCWrite)  pc_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    // One clock cycle: drive mem_ready, publish the expected outputs, advance
    task automatic cyc(input logic mr, input logic [14:0] v);
        mem_ready = mr;
        exp_vec   = v;
        exp_ret   = model_ret;
        exp_valid = 1'b1;
        n_cyc++;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [14:0] v_fetch(input logic done);
        return vec(done, done, 0, 1, 0, 0, 2'b00, 2'b10, 2'b10, 2'b10, 0);
    endfunction

    function automatic logic [14:0] v_reset();
        return vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b10, 0);
    endfunction

    // Instruction-level model: emits the expected cycle trace for one instruction
    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                         input int wf, input int wm);
        logic bt;
        opcode = op; funct3 = f3; zero = z;
        n_cyc = 0; ir_cnt = 0; mw_cnt = 0; rw_cnt = 0; pc_cnt = 0;
        for (int i = 0; i < wf; i++) cyc(1'b0, v_fetch(1'b0));
        cyc(1'b1, v_fetch(1'b1));
        cyc(1'b1, vec(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 0));
        case (op)
            7'b0000011: begin
                cyc(1'b1, vec(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10, 0));
                for (int i = 0; i < wm; i++) cyc(1'b0, vec(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
                cyc(1'b1, vec(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
                cyc(1'b1, vec(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 0));
                model_ret++;
            end
            7'b0100011: begin
                cyc(1'b1, vec(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10, 0));
                for (int i = 0; i < wm; i++) cyc(1'b0, vec(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
                cyc(1'b1, vec(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
                model_ret++;
            end
            7'b0110011, 7'b0010011: begin
                if (op == 7'b0110011)
                    cyc(1'b1, vec(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 0));
                else
                    cyc(1'b1, vec(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b11, 0));
                cyc(1'b1, vec(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
                model_ret++;
            end
            7'b1100011: begin
                bt = (f3 == 3'd0) ? z : ((f3 == 3'd1) ? ~z : 1'b0);
                cyc(1'b1, vec(bt, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0));
                model_ret++;
            end
            7'b1101111: begin
                cyc(1'b1, vec(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b10, 0));
                cyc(1'b1, vec(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
                model_ret++;
            end
            default: begin
                for (int i = 0; i < 20; i++)
                    cyc(i[0], vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1));
            end
        endcase
    endtask

    initial begin
        RST_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge CLK);
        #1;
        cyc(1'b1, v_reset());
        cyc(1'b1, v_reset());
        RST_n = 1'b1;

        instr(7'b0110011, 3'd0, 1'b0, 0, 0);
        check("r_cycles", n_cyc, 4);
        check("r_retired", int'(retired), 1);
        check("r_regwrite_pulses", rw_cnt, 1);

        instr(7'b0000011, 3'd2, 1'b0, 2, 2);
        check("load_cycles", n_cyc, 9);
        check("load_irwrite_pulses", ir_cnt, 1);
        check("load_retired", int'(retired), 2);

        instr(7'b0100011, 3'd2, 1'b0, 0, 3);
        check("store_cycles", n_cyc, 7);
        check("store_memwrite_cycles", mw_cnt, 4);
        check("store_regwrite_pulses", rw_cnt, 0);

        instr(7'b1100011, 3'd0, 1'b1, 0, 0);
        check("beq_taken_cycles", n_cyc, 3);
        check("beq_taken_pcwrites", pc_cnt, 2);
        instr(7'b1100011, 3'd1, 1'b1, 0, 0);
        check("bne_nottaken_pcwrites", pc_cnt, 1);
        instr(7'b1100011, 3'd2, 1'b1, 0, 0);
        check("b010_pcwrites", pc_cnt, 1);
        check("b010_cycles", n_cyc, 3);

        instr(7'b0010011, 3'd0, 1'b0, 1, 0);
        check("i_cycles", n_cyc, 5);

        instr(7'b1101111, 3'd0, 1'b0, 0, 0);
        check("jal_cycles", n_cyc, 4);
        check("jal_retired", int'(retired), 8);

        instr(7'b1111111, 3'd0, 1'b0, 0, 0);
        check("illegal_flag", int'(illegal), 1);
        check("illegal_retired_held", int'(retired), 8);

        // Reset out of ILLEGAL, then a store abandoned mid-MEMWRITE by reset
        RST_n = 1'b0;
        model_ret = 32'd0;
        cyc(1'b0, v_reset());
        RST_n = 1'b1;
        opcode = 7'b0100011; funct3 = 3'd2; n_cyc = 0;
        cyc(1'b1, v_fetch(1'b1));
        cyc(1'b1, vec(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 0));
        cyc(1'b1, vec(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10, 0));
        cyc(1'b0, vec(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        cyc(1'b0, vec(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        RST_n = 1'b0;
        mw_cnt = 0; rw_cnt = 0;
        cyc(1'b0, v_reset());
        cyc(1'b1, v_reset());
        check("reset_memwrite", mw_cnt, 0);
        check("reset_retired", int'(retired), 0);
        check("reset_illegal", int'(illegal), 0);
        RST_n = 1'b1;

        instr(7'b0110011, 3'd0, 1'b0, 0, 0);
        check("post_reset_retired", int'(retired), 1);

        exp_valid = 1'b0;
        @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
